// File: rtl/apb_master.sv
// APB requester bridge: one command per SETUP/ACCESS transfer, with a one-cycle
// response pulse and a wait-state timeout guard against a hung completer.
module apb_master #(
  parameter int datawidth    = 32,
  parameter int addresswidth = 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [addresswidth-1:0] cmd_addr,
  input  logic [datawidth-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  output logic [datawidth-1:0]    rsp_rdata,
  output logic                    rsp_err,
  output logic [addresswidth-1:0] paddr,
  output logic [datawidth-1:0]    pwdata,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  input  logic [datawidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]              r_state;
  logic [CW-1:0]           r_wait;
  logic [addresswidth-1:0] r_paddr;
  logic [datawidth-1:0]    r_pwdata;
  logic                    r_pwrite;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_rsp_valid;
  logic [datawidth-1:0]    r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    w_timeout;

  // Abort only while pready is low; a late pready on the limit cycle still wins.
  assign w_timeout = (TIMEOUT != 0) && (r_wait == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_write ? cmd_wdata : '0;
            r_pwrite <= cmd_write;
            r_psel   <= 1'b1;
            r_wait   <= '0;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= pslverr;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE) && rst;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a behavioural APB completer with programmable
// wait states, expected responses queued at command issue and popped on rsp_valid.
module tb_apb_master;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pwrite, psel, penable, pready, pslverr;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  apb_master #(.datawidth(DW), .addresswidth(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command and act as completer; pready rises on ACCESS cycle index 'waits'.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic [DW-1:0] rd, input logic se,
                      output int n_acc, output int lat, output bit stable,
                      output logic [63:0] ph, output logic [63:0] eh);
    rsp_t e;
    e.rdata = (w || waits > TO) ? '0 : rd;
    e.err   = (waits > TO) ? 1'b1 : se;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick;
    cmd_valid = 1'b0;
    n_acc = 0; lat = 0; stable = 1'b1; ph = '0; eh = '0;
    for (int c = 1; c < 40; c++) begin
      ph[c] = psel;
      eh[c] = penable;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      pready  = 1'b0;
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      if (psel) begin
        if (paddr !== a || pwrite !== w || pwdata !== (w ? d : '0)) stable = 1'b0;
      end
      if (psel && penable) begin
        if (n_acc == waits) begin
          pready = 1'b1; prdata = rd; pslverr = se;
        end
        n_acc++;
      end
      tick;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h5A; cmd_wdata = 32'h1;
    tick; tick;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready);
    end
    vectors++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      miscompares++; $display("FAIL reset_bus_ctl got=%b want=000", {psel, penable, pwrite});
    end
    vectors++;
    if (paddr !== '0 || pwdata !== '0) begin
      miscompares++; $display("FAIL reset_bus_data got=%h/%h want=0/0", paddr, pwdata);
    end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      miscompares++; $display("FAIL reset_rsp got=%b/%b/%h want=0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    cmd_valid = 1'b0; rst = 1'b1;
    tick;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait;
    int n, lat; bit st; logic [63:0] ph, eh; rsp_t e;
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, '0, 1'b0, n, lat, st, ph, eh);
    vectors++;
    if (lat !== 3) begin
      miscompares++; $display("FAIL wr0_latency got=%0d want=3", lat);
    end
    vectors++;
    if (ph[3:1] !== 3'b011 || eh[3:1] !== 3'b010) begin
      miscompares++; $display("FAIL wr0_psel_penable got=%b/%b want=011/010", ph[3:1], eh[3:1]);
    end
    vectors++;
    if (!st) begin
      miscompares++; $display("FAIL wr0_bus_values got=unstable want=10/DEADBEEF/1");
    end
    if (lat != 0) begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miscompares++; $display("FAIL wr0_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL wr0_rsp_pulse got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_read_waits;
    int n, lat; bit st; logic [63:0] ph, eh; rsp_t e;
    xfer(1'b0, 8'h24, 32'hFFFF0000, 2, 32'h12345678, 1'b0, n, lat, st, ph, eh);
    vectors++;
    if (n !== 3 || lat !== 5) begin
      miscompares++; $display("FAIL rd2_timing got=acc%0d/lat%0d want=acc3/lat5", n, lat);
    end
    vectors++;
    if (!st) begin
      miscompares++; $display("FAIL rd2_paddr_stable got=unstable want=24/0/0");
    end
    if (lat != 0) begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miscompares++; $display("FAIL rd2_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick;
  endtask

  task automatic test_slave_err;
    int n, lat; bit st; logic [63:0] ph, eh; rsp_t e;
    xfer(1'b1, 8'h40, 32'h00000BAD, 0, 32'h77777777, 1'b1, n, lat, st, ph, eh);
    if (lat == 0) begin
      vectors++; miscompares++; $display("FAIL err_wr_no_rsp got=none want=rsp_valid");
    end else begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miscompares++; $display("FAIL err_wr_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick;
    xfer(1'b0, 8'h44, '0, 0, 32'hCAFE0001, 1'b0, n, lat, st, ph, eh);
    if (lat == 0) begin
      vectors++; miscompares++; $display("FAIL err_rd_no_rsp got=none want=rsp_valid");
    end else begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miscompares++; $display("FAIL err_rd_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick;
  endtask

  task automatic test_timeout;
    int n, lat; bit st; logic [63:0] ph, eh; rsp_t e;
    xfer(1'b0, 8'h30, '0, 100, 32'h55, 1'b0, n, lat, st, ph, eh);
    vectors++;
    if (n !== TO + 1 || lat !== TO + 3 || ph[lat] !== 1'b0) begin
      miscompares++; $display("FAIL to_abort got=acc%0d/lat%0d/psel%b want=acc%0d/lat%0d/psel0",
                              n, lat, ph[lat], TO + 1, TO + 3);
    end
    if (lat != 0) begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miscompares++; $display("FAIL to_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick;
    xfer(1'b0, 8'h31, '0, TO, 32'h55, 1'b0, n, lat, st, ph, eh);
    vectors++;
    if (n !== TO + 1 || lat !== TO + 3) begin
      miscompares++; $display("FAIL to_edge_timing got=acc%0d/lat%0d want=acc%0d/lat%0d", n, lat, TO + 1, TO + 3);
    end
    if (lat != 0) begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miscompares++; $display("FAIL to_edge_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic          wr [3] = '{1'b1, 1'b0, 1'b0};
    logic [AW-1:0] ad [3] = '{8'h50, 8'h54, 8'h58};
    logic [DW-1:0] rd [3] = '{32'h0, 32'hA5A50001, 32'hA5A50002};
    int   rc [3] = '{0, 0, 0};
    int   pres = 0, nr = 0;
    bit   upd = 1'b1;
    logic [63:0] ph = '0;
    rsp_t e;
    e.rdata = '0; e.err = 1'b0;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr[0]; cmd_addr = ad[0]; cmd_wdata = 32'h1111;
    tick;
    for (int c = 1; c < 16 && nr < 3; c++) begin
      ph[c] = psel;
      if (upd) begin
        upd = 1'b0;
        pres++;
        if (pres < 3) begin
          cmd_write = wr[pres]; cmd_addr = ad[pres]; cmd_wdata = 32'h2222;
          e.rdata = wr[pres] ? '0 : rd[pres]; e.err = 1'b0;
          sb.push_back(e);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        rc[nr] = c;
        e = sb.pop_front();
        vectors++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          miscompares++; $display("FAIL b2b_rsp%0d got=%h/%b want=%h/%b", nr, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        nr++;
        upd = 1'b1;
      end
      pready  = psel && penable;
      prdata  = (nr < 3) ? rd[nr] : '0;
      pslverr = 1'b0;
      if (nr < 3) tick;
    end
    cmd_valid = 1'b0; pready = 1'b0; prdata = '0;
    vectors++;
    if (rc[0] !== 3 || rc[1] !== 6 || rc[2] !== 9) begin
      miscompares++; $display("FAIL b2b_rsp_cycles got=%0d,%0d,%0d want=3,6,9", rc[0], rc[1], rc[2]);
    end
    vectors++;
    if (ph[9:1] !== 9'b011011011) begin
      miscompares++; $display("FAIL b2b_psel_gaps got=%b want=011011011", ph[9:1]);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int n, lat; bit st; logic [63:0] ph, eh; rsp_t e;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h7E; cmd_wdata = 32'h89ABCDEF;
    pready = 1'b0;
    tick;
    cmd_valid = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    vectors++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready} !== 6'b0 ||
        paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
      miscompares++; $display("FAIL midrst_outputs got=%b%b%b%b%b%b/%h/%h/%h want=000000/0/0/0",
                              psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready, paddr, pwdata, rsp_rdata);
    end
    rst = 1'b1;
    tick;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL midrst_release got=rv%b/rdy%b want=rv0/rdy1", rsp_valid, cmd_ready);
    end
    xfer(1'b0, 8'h0C, '0, 0, 32'h0BADF00D, 1'b0, n, lat, st, ph, eh);
    vectors++;
    if (lat !== 3) begin
      miscompares++; $display("FAIL midrst_after_lat got=%0d want=3", lat);
    end
    if (lat != 0) begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        miscompares++; $display("FAIL midrst_after_rsp got=%h/%b want=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    tick;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    test_reset;
    test_write_zero_wait;
    test_read_waits;
    test_slave_err;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
